// File: rtl/pe_weight_bank_b2_if.sv
// Weight-bank bus: B2 loader side plus PE read port.
// The master drives loader/read requests; the slave is the bank.
interface pe_weight_bank_b2_if;
    logic [6:0]  w_0;
    logic [6:0]  w_1;
    logic [6:0]  w_2;
    logic [6:0]  w_3;
    logic [6:0]  w_4;
    logic [6:0]  w_5;
    logic [6:0]  w_6;
    logic [6:0]  w_7;
    logic [15:0] new_weight_val;
    logic        Weight_Trans_Done;
    logic        rd_en;
    logic [3:0]  rd_ch;
    logic [55:0] rd_data;
    logic        rd_valid;
    logic        bank_ready;
    logic [15:0] cap_mask;
    logic        load_err;

    modport master (
        output w_0, w_1, w_2, w_3,
        output w_4, w_5, w_6, w_7,
        output new_weight_val,
        output Weight_Trans_Done,
        output rd_en, rd_ch,
        input  rd_data, rd_valid,
        input  bank_ready, cap_mask,
        input  load_err
    );

    modport slave (
        input  w_0, w_1, w_2, w_3,
        input  w_4, w_5, w_6, w_7,
        input  new_weight_val,
        input  Weight_Trans_Done,
        input  rd_en, rd_ch,
        output rd_data, rd_valid,
        output bank_ready, cap_mask,
        output load_err
    );
endinterface

// File: rtl/pe_weight_bank_b2.sv
// 16x56b per-channel weight bank captured from thermometer-mask rises.
// Optional protocol checker: define WEIGHT_BANK_CHECK_EN.
module pe_weight_bank_b2 (
    input  logic clk,
    input  logic rst_n,
    pe_weight_bank_b2_if.slave bus
);

    logic [15:0] r_nwv_q;
    logic [15:0] r_cap_mask;
    logic        r_done;
    logic        r_ready;
    logic        r_rd_valid;
    logic [55:0] r_rd_data;
    logic [55:0] r_mem [16];

    logic [15:0] w_rise;
    logic        w_restart;
    logic        w_cap_en;
    logic [3:0]  w_cap_idx;
    logic [55:0] w_wdata;
    logic        w_rd_fire;

    assign w_rise    = bus.new_weight_val & ~r_nwv_q;
    assign w_restart = (bus.new_weight_val == 16'h0)
                    && (r_nwv_q != 16'h0);
    assign w_cap_en  = |w_rise;
    assign w_rd_fire = bus.rd_en && r_ready;
    assign w_wdata   = {bus.w_0, bus.w_1, bus.w_2, bus.w_3,
                        bus.w_4, bus.w_5, bus.w_6, bus.w_7};

    // Lowest set rise bit wins; higher simultaneous rises are dropped.
    always_comb begin
        w_cap_idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_rise[k]) w_cap_idx = 4'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nwv_q    <= 16'h0;
            r_cap_mask <= 16'h0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 56'h0;
            for (int k = 0; k < 16; k++) begin
                r_mem[k] <= 56'h0;
            end
        end else begin
            r_nwv_q <= bus.new_weight_val;
            if (w_cap_en) r_mem[w_cap_idx] <= w_wdata;
            if (w_restart) begin
                r_cap_mask <= 16'h0;
                r_done     <= 1'b0;
                r_ready    <= 1'b0;
            end else begin
                if (w_cap_en) r_cap_mask[w_cap_idx] <= 1'b1;
                if (bus.Weight_Trans_Done) r_done <= 1'b1;
                r_ready <= (r_cap_mask == 16'hFFFF) && r_done;
            end
            // Memory read sees the pre-write entry on a same-edge capture.
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_rd_data <= r_mem[bus.rd_ch];
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.bank_ready = r_ready;
    assign bus.cap_mask   = r_cap_mask;

`ifdef WEIGHT_BANK_CHECK_EN
    logic r_wtd_q;
    logic r_load_err;
    logic w_multi_rise;
    logic w_not_therm;
    logic w_early_done;

    assign w_multi_rise = (w_rise & (w_rise - 16'h1)) != 16'h0;
    assign w_not_therm  = (bus.new_weight_val
                        & (bus.new_weight_val + 16'h1)) != 16'h0;
    assign w_early_done = bus.Weight_Trans_Done && !r_wtd_q
                       && (r_cap_mask != 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wtd_q    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wtd_q <= bus.Weight_Trans_Done;
            if (w_multi_rise || w_not_therm || w_early_done)
                r_load_err <= 1'b1;
        end
    end

    assign bus.load_err = r_load_err;
`else
    assign bus.load_err = 1'b0;
`endif

endmodule

// File: doc/pe_weight_bank_b2.md
PE_WEIGHT_BANK_B2 -- requirements
Module: pe_weight_bank_b2

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
  clk  input  1  single clock; all state updates on rising edge
  rst_n  input  1  asynchronous active-low reset
  w_0 .. w_7  input  7 each  weight bus from the B2 weight loader; w_0..w_3 and w_4..w_7 may update on different cycles
  new_weight_val  input  16  thermometer mask; bit k rising means all eight weights of output channel k are valid on w_0..w_7 in that same cycle
  Weight_Trans_Done  input  1  sticky load-complete indication from the loader
  rd_en  input  1  read request from the PE datapath
  rd_ch  input  4  output channel to read (0..15)
  rd_data  output  56  {w_0,...,w_7} of channel rd_ch; w_0 in bits [55:49]
  rd_valid  output  1  rd_data valid, one-cycle pulse
  bank_ready  output  1  all 16 channels captured and load complete
  cap_mask  output  16  channels captured in the current epoch
  load_err  output  1  sticky protocol error (see Configuration)

Function
REQ-002 Storage SHALL be 16 entries x 56 bits, indexed by channel.
REQ-003 The module SHALL register new_weight_val as nwv_q each cycle; rise = new_weight_val & ~nwv_q.
REQ-004 When rise has exactly one bit k set, the module SHALL write {w_0..w_7} into entry k and set cap_mask[k] on that same rising edge (zero-cycle sampling; no input delay).
REQ-005 When rise has more than one bit set, the lowest set bit SHALL be captured and the remaining bits ignored (cap_mask not set for them).
REQ-006 A capture into an already-captured channel SHALL overwrite the entry; cap_mask unchanged.
REQ-007 Epoch restart: when new_weight_val == 0 and nwv_q != 0, cap_mask, the done flag and bank_ready SHALL clear on the next edge; entry contents SHALL be retained.
REQ-008 A done flag SHALL set when Weight_Trans_Done == 1 and hold until epoch restart or reset.
REQ-009 bank_ready SHALL be registered: 1 the cycle after (cap_mask == 16'hFFFF && done flag == 1), else 0.
REQ-010 Read: rd_en == 1 with bank_ready == 1 SHALL produce rd_valid = 1 and rd_data = entry[rd_ch] exactly one cycle later.
REQ-011 rd_en while bank_ready == 0 SHALL be ignored: rd_valid stays 0, rd_data holds its previous value.
REQ-012 A read and a capture to the same entry on the same edge SHALL return the old (pre-write) entry value.
REQ-013 Back-to-back reads on consecutive cycles SHALL each produce their own rd_valid pulse (full throughput, no stall).

Reset
REQ-014 On rst_n low, asynchronously: nwv_q = 0, cap_mask = 0, done flag = 0, bank_ready = 0, rd_valid = 0, rd_data = 0, load_err = 0; all 16 entries = 0.
REQ-015 Reset deassertion mid-load SHALL start a fresh epoch; bits already high on new_weight_val SHALL be treated as rises on the first post-reset edge.

Configuration
REQ-016 Macro WEIGHT_BANK_CHECK_EN: when defined, load_err SHALL set (sticky until reset) on any of: rise with more than one bit set; new_weight_val not of form 2^n-1; Weight_Trans_Done rising while cap_mask != 16'hFFFF.
REQ-017 When WEIGHT_BANK_CHECK_EN is undefined, load_err SHALL be tied 0 and no check logic instantiated; all other behaviour identical.

Verification
REQ-018 Loader sequence: 16 rises, channel k weights = {7'(k),7'(k+1),...,7'(k+7)}, then Done -> cap_mask=16'hFFFF, bank_ready=1 one cycle after Done, load_err=0.
REQ-019 After ready, rd_en with rd_ch=5 -> next cycle rd_valid=1, rd_data={7'd5,7'd6,...,7'd12}; rd_ch=15 then 0 back-to-back -> two consecutive valid pulses with correct data.
REQ-020 rd_en=1 during load (cap_mask=16'h00FF) -> rd_valid stays 0, rd_data unchanged.
REQ-021 new_weight_val jumps 16'h0001 -> 16'h0007 (CHECK_EN defined) -> only channel 1 captured, load_err=1; CHECK_EN undefined -> load_err=0.
REQ-022 After ready, new_weight_val -> 0 -> next cycle cap_mask=0, bank_ready=0; re-load with new values -> reads return new values.
REQ-023 rst_n pulsed low mid-load (cap_mask=16'h003F) -> all outputs 0 immediately, no rd_valid until a full new epoch completes.
